// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every handshake and bus signal of the two-port memory arbiter into
// one interface. Clock and reset are kept outside the bundle.
//
// Port summary (signal names are the arbiter's external port names):
//   Fetch port : if_req, if_addr -> arbiter ; if_gnt, if_valid, if_rdata <- arbiter
//   Data port  : d_req, d_we, d_ctrl, d_addr, d_wdata -> arbiter ;
//                d_gnt, d_valid, d_rdata <- arbiter
//   Status     : timeout_err <- arbiter
//   Memory     : mem_req, mem_we, mem_ctrl, mem_addr, mem_wdata <- arbiter ;
//                mem_rdata, mem_ready -> arbiter
//
// Modports:
//   slave  - the arbiter itself
//   master - the surroundings (requesters plus memory), e.g. a testbench
interface mem_arbiter_if #(
  parameter int WIDTH = 64
);

  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_valid;
  logic [WIDTH-1:0] if_rdata;

  logic             d_req;
  logic             d_we;
  logic [2:0]       d_ctrl;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_gnt;
  logic             d_valid;
  logic [WIDTH-1:0] d_rdata;

  logic             timeout_err;

  logic             mem_req;
  logic             mem_we;
  logic [2:0]       mem_ctrl;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_rdata,
    input  d_req, d_we, d_ctrl, d_addr, d_wdata,
    output d_gnt, d_valid, d_rdata,
    output timeout_err,
    output mem_req, mem_we, mem_ctrl, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_rdata,
    output d_req, d_we, d_ctrl, d_addr, d_wdata,
    input  d_gnt, d_valid, d_rdata,
    input  timeout_err,
    input  mem_req, mem_we, mem_ctrl, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between an instruction-fetch requester and a data
// requester. A three-state FSM (IDLE -> BUSY -> RESP -> IDLE) accepts one
// access at a time, holds it on the memory port until mem_ready, and returns
// the read data to the owner with a one-cycle valid pulse. If the memory
// stays silent for TIMEOUT BUSY cycles the access is aborted with a
// timeout_err pulse and a zero-data valid pulse to the owner. All outputs
// come straight from registers.
//
// Parameters:
//   WIDTH   - address/data width
//   TIMEOUT - BUSY cycles allowed before abort (>= 1)
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mem_arbiter_if.slave carrying the fetch, data and memory signals
//
// Build option:
//   MEM_ARBITER_RR_EN - when defined, simultaneous requests are resolved
//   round-robin (the port not granted last wins). When undefined, the data
//   port always wins a collision and there is no pointer state.
module mem_arbiter #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_owner_d;
  logic [CW-1:0]    r_cnt;

  logic             r_if_gnt;
  logic             r_if_valid;
  logic [WIDTH-1:0] r_if_rdata;
  logic             r_d_gnt;
  logic             r_d_valid;
  logic [WIDTH-1:0] r_d_rdata;
  logic             r_timeout_err;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [2:0]       r_mem_ctrl;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;

  logic             w_any_req;
  logic             w_pick_d;

  assign w_any_req = bus.d_req | bus.if_req;

`ifdef MEM_ARBITER_RR_EN
  // r_ptr_d = 1 means the data port is preferred on the next collision.
  logic r_ptr_d;
  assign w_pick_d = bus.d_req & (~bus.if_req | r_ptr_d);
`else
  assign w_pick_d = bus.d_req;
`endif

  // Main controller: arbitration in IDLE, holding the access on the memory
  // port in BUSY with a cycle budget, and one response cycle in RESP. Every
  // pulse output defaults low each cycle and is raised only by the branch
  // that owns it. A timed-out access returns straight to IDLE, so its pulse
  // cycle is already a new arbitration cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_owner_d     <= 1'b0;
      r_cnt         <= '0;
      r_if_gnt      <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_rdata    <= '0;
      r_d_gnt       <= 1'b0;
      r_d_valid     <= 1'b0;
      r_d_rdata     <= '0;
      r_timeout_err <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_ctrl    <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
`ifdef MEM_ARBITER_RR_EN
      r_ptr_d       <= 1'b1;
`endif
    end else begin
      r_if_gnt      <= 1'b0;
      r_d_gnt       <= 1'b0;
      r_if_valid    <= 1'b0;
      r_d_valid     <= 1'b0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state   <= BUSY;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
            r_owner_d <= w_pick_d;
`ifdef MEM_ARBITER_RR_EN
            r_ptr_d   <= ~w_pick_d;
`endif
            if (w_pick_d) begin
              r_d_gnt     <= 1'b1;
              r_mem_we    <= bus.d_we;
              r_mem_ctrl  <= bus.d_ctrl;
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
            end else begin
              r_if_gnt    <= 1'b1;
              r_mem_we    <= 1'b0;
              r_mem_ctrl  <= 3'b010;
              r_mem_addr  <= bus.if_addr;
              r_mem_wdata <= '0;
            end
          end
        end
        BUSY: begin
          // mem_ready is checked first so a completion arriving in the
          // last budgeted cycle beats the timeout.
          if (bus.mem_ready) begin
            r_state   <= RESP;
            r_mem_req <= 1'b0;
            if (r_owner_d) begin
              r_d_valid <= 1'b1;
              r_d_rdata <= r_mem_we ? '0 : bus.mem_rdata;
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= bus.mem_rdata;
            end
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_timeout_err <= 1'b1;
            if (r_owner_d) begin
              r_d_valid <= 1'b1;
            end else begin
              r_if_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt      = r_if_gnt;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_rdata    = r_if_rdata;
  assign bus.d_gnt       = r_d_gnt;
  assign bus.d_valid     = r_d_valid;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.timeout_err = r_timeout_err;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_ctrl    = r_mem_ctrl;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives both requesters and plays the memory for mem_arbiter. Each access is
// described at transaction level: the memory latency is chosen up front, and
// the expected outputs of every cycle follow from that latency with simple
// arithmetic (grant one cycle after the request is seen, BUSY until ready or
// the budget runs out, then a response or a timeout pulse). A single compare
// process checks the DUT against those expectations every cycle and also
// records a few observations that directed scenarios check against literals.
module tb_mem_arbiter;

  localparam int W  = 64;
  localparam int TO = 4;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(W)) bus ();

  mem_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  logic modelOn   = 1'b0;

  // Expected outputs for the current cycle.
  logic         eIfGnt, eDGnt, eIfValid, eDValid, eTo, eMemReq, eMemWe, eAllZero;
  logic [2:0]   eMemCtrl;
  logic [W-1:0] eMemAddr, eMemWdata, eIfRdata, eDRdata;

  // Requester state.
  logic         ifPend = 1'b0;
  logic [W-1:0] ifAddr = '0;
  logic         dPend  = 1'b0;
  logic         dWe    = 1'b0;
  logic [2:0]   dCtrl  = '0;
  logic [W-1:0] dAddr  = '0;
  logic [W-1:0] dWdata = '0;
  logic         prefD  = 1'b1;
  logic         useFixed = 1'b0;
  logic [W-1:0] fixedRdata = '0;

  // Observations of the DUT, written only by the compare process.
  int           obsMemReqCnt = 0, obsToCnt = 0, obsIfValidCnt = 0, obsDValidCnt = 0;
  int           obsIfValidCyc = 0, obsDValidCyc = 0, obsIfGntCyc = 0, obsDGntCyc = 0;
  logic [W-1:0] obsMemAddr = '0, obsMemWdata = '0, obsIfRdata = '0, obsDRdata = '0;
  logic [2:0]   obsMemCtrl = '0;
  logic         obsMemWe = 1'b0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare process: samples mid-cycle, records observations, and checks
  // every output against the expectation for this cycle.
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      obsMemReqCnt++;
      obsMemAddr  = bus.mem_addr;
      obsMemWdata = bus.mem_wdata;
      obsMemCtrl  = bus.mem_ctrl;
      obsMemWe    = bus.mem_we;
    end
    if (bus.timeout_err === 1'b1) obsToCnt++;
    if (bus.if_valid === 1'b1) begin
      obsIfValidCnt++;
      obsIfValidCyc = cyc;
      obsIfRdata    = bus.if_rdata;
    end
    if (bus.d_valid === 1'b1) begin
      obsDValidCnt++;
      obsDValidCyc = cyc;
      obsDRdata    = bus.d_rdata;
    end
    if (bus.if_gnt === 1'b1) obsIfGntCyc = cyc;
    if (bus.d_gnt === 1'b1) obsDGntCyc = cyc;
    if (modelOn) begin
      checkOutput("if_gnt", W'(bus.if_gnt), W'(eIfGnt));
      checkOutput("d_gnt", W'(bus.d_gnt), W'(eDGnt));
      checkOutput("if_valid", W'(bus.if_valid), W'(eIfValid));
      checkOutput("d_valid", W'(bus.d_valid), W'(eDValid));
      checkOutput("timeout_err", W'(bus.timeout_err), W'(eTo));
      checkOutput("mem_req", W'(bus.mem_req), W'(eMemReq));
      if (eMemReq || eAllZero) begin
        checkOutput("mem_we", W'(bus.mem_we), W'(eMemWe));
        checkOutput("mem_ctrl", W'(bus.mem_ctrl), W'(eMemCtrl));
        checkOutput("mem_addr", bus.mem_addr, eMemAddr);
        checkOutput("mem_wdata", bus.mem_wdata, eMemWdata);
      end
      if (eIfValid || eAllZero) checkOutput("if_rdata", bus.if_rdata, eIfRdata);
      if (eDValid || eAllZero) checkOutput("d_rdata", bus.d_rdata, eDRdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clearExp();
    eIfGnt = 1'b0; eDGnt = 1'b0; eIfValid = 1'b0; eDValid = 1'b0; eTo = 1'b0;
    eMemReq = 1'b0; eMemWe = 1'b0; eMemCtrl = '0; eMemAddr = '0; eMemWdata = '0;
    eIfRdata = '0; eDRdata = '0; eAllZero = 1'b0;
  endtask

  task automatic driveReqs();
    bus.if_req  = ifPend;
    bus.if_addr = ifAddr;
    bus.d_req   = dPend;
    bus.d_we    = dWe;
    bus.d_ctrl  = dCtrl;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
  endtask

  // A port may start a new request unless it is already waiting or is
  // receiving its valid pulse in this very cycle.
  task automatic maybeRaise(input int pct);
    if (!ifPend && !eIfValid && $urandom_range(0, 99) < pct) begin
      ifPend = 1'b1;
      ifAddr = {$urandom, $urandom};
    end
    if (!dPend && !eDValid && $urandom_range(0, 99) < pct) begin
      dPend  = 1'b1;
      dWe    = 1'($urandom_range(0, 1));
      dCtrl  = 3'($urandom_range(0, 7));
      dAddr  = {$urandom, $urandom};
      dWdata = {$urandom, $urandom};
    end
  endtask

  task automatic applyReset();
    rst    = 1'b1;
    ifPend = 1'b0;
    dPend  = 1'b0;
    driveReqs();
    step();
    clearExp();
    eAllZero = 1'b1;
    rst      = 1'b0;
    prefD    = 1'b1;
  endtask

  // Called inside an arbitration cycle whose expectations are already set.
  // lat: extra cycles before mem_ready (ready in BUSY cycle lat+1; lat >= TO
  // never answers in time). abortAt: BUSY cycle in which reset is raised
  // (0 = never). Returns inside the next arbitration cycle.
  task automatic applyStimulus(input int lat, input int abortAt);
    logic         winD;
    logic         fWe;
    logic [2:0]   fCtrl;
    logic [W-1:0] fAddr, fWdata, rd;
    rd = '0;
    driveReqs();
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = {$urandom, $urandom};
    if (!ifPend && !dPend) begin
      step();
      clearExp();
      return;
    end
    winD  = dPend && (!ifPend || !RR_MODE || prefD);
    prefD = !winD;
    if (winD) begin
      fWe = dWe; fCtrl = dCtrl; fAddr = dAddr; fWdata = dWdata;
    end else begin
      fWe = 1'b0; fCtrl = 3'b010; fAddr = ifAddr; fWdata = '0;
    end
    for (int j = 1; j <= TO; j++) begin
      step();
      clearExp();
      eIfGnt    = (j == 1) && !winD;
      eDGnt     = (j == 1) && winD;
      eMemReq   = 1'b1;
      eMemWe    = fWe;
      eMemCtrl  = fCtrl;
      eMemAddr  = fAddr;
      eMemWdata = fWdata;
      maybeRaise(20);
      driveReqs();
      if (winD) begin
        bus.d_addr  = {$urandom, $urandom};
        bus.d_wdata = {$urandom, $urandom};
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_ctrl  = 3'($urandom_range(0, 7));
      end else begin
        bus.if_addr = {$urandom, $urandom};
      end
      bus.mem_rdata = useFixed ? fixedRdata : {$urandom, $urandom};
      bus.mem_ready = (j == lat + 1);
      if (j == abortAt) begin
        bus.mem_ready = 1'b0;
        applyReset();
        driveReqs();
        return;
      end
      if (j == lat + 1) begin
        rd = bus.mem_rdata;
        break;
      end
    end
    step();
    clearExp();
    if (winD) dPend = 1'b0; else ifPend = 1'b0;
    eIfValid = !winD;
    eDValid  = winD;
    if (lat < TO) begin
      eIfRdata = winD ? '0 : rd;
      eDRdata  = (winD && !fWe) ? rd : '0;
      maybeRaise(30);
      driveReqs();
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = {$urandom, $urandom};
      step();
      clearExp();
    end else begin
      eTo = 1'b1;
      driveReqs();
      bus.mem_ready = 1'b0;
    end
  endtask

  initial begin
    int s, a0, a1, a2, lat, ab;
    clearExp();
    driveReqs();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    rst = 1'b1;
    step();
    eAllZero = 1'b1;
    modelOn  = 1'b1;
    rst      = 1'b0;

    // Single fetch, memory answers two cycles after mem_req rises.
    ifPend = 1'b1; ifAddr = 64'h1000;
    useFixed = 1'b1; fixedRdata = 64'h0123_4567_89AB_CDEF;
    s = cyc;
    applyStimulus(2, 0);
    @(negedge clk); #1;
    checkOutput("fetch_mem_addr", obsMemAddr, 64'h1000);
    checkOutput("fetch_mem_ctrl", W'(obsMemCtrl), 64'd2);
    checkOutput("fetch_gnt_latency", W'(obsIfGntCyc - s), 64'd1);
    checkOutput("fetch_valid_latency", W'(obsIfValidCyc - s), 64'd4);
    checkOutput("fetch_rdata", obsIfRdata, 64'h0123_4567_89AB_CDEF);

    // Collision: data wins first, fetch goes after the data response.
    ifPend = 1'b1; ifAddr = 64'h2000;
    dPend = 1'b1; dWe = 1'b0; dCtrl = 3'b011; dAddr = 64'h3000; dWdata = '0;
    s = cyc;
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    @(negedge clk); #1;
    checkOutput("collide_d_gnt", W'(obsDGntCyc - s), 64'd1);
    checkOutput("collide_if_gnt", W'(obsIfGntCyc - s), 64'd4);

    // Store: write data on the memory port, zero read data returned.
    dPend = 1'b1; dWe = 1'b1; dCtrl = 3'b011; dAddr = 64'h20; dWdata = 64'hDEADBEEF;
    fixedRdata = 64'hFFFF_0000_FFFF_0000;
    a0 = obsDValidCnt;
    applyStimulus(2, 0);
    @(negedge clk); #1;
    checkOutput("store_mem_we", W'(obsMemWe), 64'd1);
    checkOutput("store_mem_wdata", obsMemWdata, 64'hDEADBEEF);
    checkOutput("store_mem_addr", obsMemAddr, 64'h20);
    checkOutput("store_d_rdata", obsDRdata, 64'h0);
    checkOutput("store_valid_count", W'(obsDValidCnt - a0), 64'd1);

    // Memory never answers: abort after TO BUSY cycles.
    ifPend = 1'b1; ifAddr = 64'h4000;
    a0 = obsMemReqCnt; a1 = obsToCnt; a2 = obsIfValidCnt;
    applyStimulus(TO, 0);
    @(negedge clk); #1;
    checkOutput("timeout_busy_cycles", W'(obsMemReqCnt - a0), 64'd4);
    checkOutput("timeout_pulses", W'(obsToCnt - a1), 64'd1);
    checkOutput("timeout_valid_pulses", W'(obsIfValidCnt - a2), 64'd1);
    checkOutput("timeout_rdata", obsIfRdata, 64'h0);

    // Ready arriving in the last budgeted cycle completes normally.
    dPend = 1'b1; dWe = 1'b0; dCtrl = 3'b001; dAddr = 64'h40;
    fixedRdata = 64'h5555_AAAA_1234_5678;
    a1 = obsToCnt; a2 = obsDValidCnt;
    applyStimulus(TO - 1, 0);
    @(negedge clk); #1;
    checkOutput("edge_ready_no_timeout", W'(obsToCnt - a1), 64'd0);
    checkOutput("edge_ready_valid", W'(obsDValidCnt - a2), 64'd1);
    checkOutput("edge_ready_rdata", obsDRdata, 64'h5555_AAAA_1234_5678);

    // Reset in the middle of BUSY, then a late mem_ready must be ignored.
    dPend = 1'b1; dWe = 1'b1; dCtrl = 3'b011; dAddr = 64'h80; dWdata = 64'h77;
    a0 = obsDValidCnt; a1 = obsIfValidCnt; a2 = obsToCnt;
    applyStimulus(3, 2);
    for (int i = 0; i < 3; i++) begin
      driveReqs();
      bus.mem_ready = 1'b1;
      step();
      clearExp();
    end
    @(negedge clk); #1;
    checkOutput("abort_no_d_valid", W'(obsDValidCnt - a0), 64'd0);
    checkOutput("abort_no_if_valid", W'(obsIfValidCnt - a1), 64'd0);
    checkOutput("abort_no_timeout", W'(obsToCnt - a2), 64'd0);

    // A request in the first cycle after reset is arbitrated normally.
    applyReset();
    dPend = 1'b1; dWe = 1'b0; dCtrl = 3'b010; dAddr = 64'h100;
    ifPend = 1'b1; ifAddr = 64'h200;
    s = cyc;
    applyStimulus(1, 0);
    @(negedge clk); #1;
    checkOutput("post_reset_gnt", W'(obsDGntCyc - s), 64'd1);

    // Randomised traffic against the transaction model.
    useFixed = 1'b0;
    for (int k = 0; k < 250; k++) begin
      maybeRaise(60);
      lat = ($urandom_range(0, 5) == 0) ? TO : $urandom_range(0, TO - 1);
      ab  = ($urandom_range(0, 29) == 0) ? $urandom_range(1, TO) : 0;
      applyStimulus(lat, ab);
    end
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
